// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state enum, default widths and counter-width helper for bcd_conv_seq
package bcd_pkg;
  localparam int BIN_W_D = 10;
  localparam int DIG_D = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration; d={bcd,bin} in, q=add-3 per digit then shift left by 1
module bcd_dabble_step #(
  parameter int BIN_W = 10,
  parameter int DIG = 4
) (
  input  logic [4*DIG+BIN_W-1:0] d,
  output logic [4*DIG+BIN_W-1:0] q
);
  logic [4*DIG+BIN_W-1:0] a;
  assign a[BIN_W-1:0] = d[BIN_W-1:0];
  for (genvar g = 0; g < DIG; g++) begin : g_dig
    assign a[BIN_W+4*g +: 4] = d[BIN_W+4*g +: 4] >= 4'd5 ? d[BIN_W+4*g +: 4] + 4'd3 : d[BIN_W+4*g +: 4];
  end
  assign q = a << 1;
endmodule

// File: rtl/bcd_conv_seq.sv
// bcd_conv_seq: sequential binary-to-BCD converter; bin in via in_valid/in_ready, bcd+ovf3 out via out_valid/out_ready, busy while shifting
module bcd_conv_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_D,
  parameter int DIG = DIG_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*DIG-1:0] bcd,
  output logic             ovf3,
  output logic             busy
);
  localparam int W = 4*DIG + BIN_W;
  localparam int CW = cnt_w(BIN_W);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [W-1:0] sr, nxt;
  logic last;
  bcd_dabble_step #(.BIN_W(BIN_W), .DIG(DIG)) u_step (.d(sr), .q(nxt));
  assign last = cnt == CW'(BIN_W - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) :
                               (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = state == IDLE;
    busy = state == SHIFT;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sr <= '0;
      bcd <= '0;
      ovf3 <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sr <= {{4*DIG{1'b0}}, bin};
      cnt <= '0;
    end else if (state == SHIFT) begin
      sr <= nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        bcd <= nxt[W-1:BIN_W];
        ovf3 <= |nxt[W-1:BIN_W+12];
      end
    end
endmodule
